// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: load-size and HI/LO select codes,
// the access FSM states, and the alignment rule used by the optional check.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    EXTR_WORD  = 2'b00,
    EXTR_BYTE  = 2'b01,
    EXTR_HALF  = 2'b10,
    EXTR_WORD3 = 2'b11
  } extr_t;

  typedef enum logic [1:0] {
    LH_NONE = 2'b00,
    LH_LO   = 2'b01,
    LH_HI   = 2'b10,
    LH_RSVD = 2'b11
  } lh_sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Store size comes from Sb/Sh, load size from ExtrWord; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] a, input logic is_store,
                                         input logic sb, input logic sh,
                                         input logic [1:0] extr);
    logic byte_op;
    logic half_op;
    if (is_store) begin
      byte_op = sb;
      half_op = ~sb & sh;
    end else begin
      byte_op = (extr == EXTR_BYTE);
      half_op = (extr == EXTR_HALF);
    end
    if (byte_op) return 1'b0;
    if (half_op) return a[0];
    return (a != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between mem_stage (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int DATA_BITS = 32
);
  // Handshake: the master raises dmem_req and holds addr/we/wstrb/wdata stable
  // until the slave returns a single-cycle dmem_ack (with dmem_rdata for loads).
  logic                 dmem_req;
  logic                 dmem_we;
  logic [DATA_BITS-1:0] dmem_addr;
  logic [3:0]           dmem_wstrb;
  logic [DATA_BITS-1:0] dmem_wdata;
  logic [DATA_BITS-1:0] dmem_rdata;
  logic                 dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store strobes and lane replication, plus
// little-endian load extraction with sign/zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sb,
  input  logic        i_sh,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_extr_word,
  input  logic        i_extr_signed,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_store_data;
    if (i_sb) begin
      o_wstrb = 4'b0001 << i_addr_lo;
      o_wdata = {4{i_store_data[7:0]}};
    end else if (i_sh) begin
      o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      o_wdata = {2{i_store_data[15:0]}};
    end
  end

  always_comb begin
    w_byte      = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    o_load_data = i_rdata;
    case (extr_t'(i_extr_word))
      EXTR_BYTE: o_load_data = i_extr_signed ? {{24{w_byte[7]}}, w_byte}
                                             : {24'b0, w_byte};
      EXTR_HALF: o_load_data = i_extr_signed ? {{16{w_half[15]}}, w_half}
                                             : {16'b0, w_half};
      default:   o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs the IDLE/ACCESS handshake FSM against the data
// memory and registers the MEM/WB bundle. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_BITS   = 32,
  parameter int IR_BITS   = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [PC_BITS-1:0]   pc_in,
  input  logic [IR_BITS-1:0]   ir_in,
  input  logic [DATA_BITS-1:0] result_1,
  input  logic [DATA_BITS-1:0] result_2,
  input  logic [DATA_BITS-1:0] store_data,
  input  logic [5:0]           write,
  input  logic                 MemToReg,
  input  logic                 MemWrite,
  input  logic                 RegWrite,
  input  logic                 Jal,
  input  logic                 ToLH,
  input  logic                 Sh,
  input  logic                 Sb,
  input  logic                 ExtrSigned,
  input  logic                 Syscall,
  input  logic [1:0]           ExtrWord,
  input  logic [1:0]           LHToReg,
  input  logic [DATA_BITS-1:0] lo,
  input  logic [DATA_BITS-1:0] hi,
  output logic                 mem_busy,
  mem_stage_if.master          dmem,
  output logic                 wb_valid,
  output logic                 wb_RegWrite,
  output logic                 wb_ToLH,
  output logic                 wb_Syscall,
  output logic [5:0]           wb_write,
  output logic [DATA_BITS-1:0] wb_data,
  output logic [DATA_BITS-1:0] wb_result_1,
  output logic [DATA_BITS-1:0] wb_result_2,
  output logic [PC_BITS-1:0]   wb_pc,
  output logic [IR_BITS-1:0]   wb_ir,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                 wb_addr_err,
`endif
  output state_t               o_dbg_state
);

  typedef struct packed {
    logic [PC_BITS-1:0]   pc;
    logic [IR_BITS-1:0]   ir;
    logic [DATA_BITS-1:0] r1;
    logic [DATA_BITS-1:0] r2;
    logic [DATA_BITS-1:0] sd;
    logic [DATA_BITS-1:0] lo;
    logic [DATA_BITS-1:0] hi;
    logic [5:0]           write;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 reg_write;
    logic                 jal;
    logic                 to_lh;
    logic                 sh;
    logic                 sb;
    logic                 extr_signed;
    logic                 syscall;
    logic [1:0]           extr_word;
    logic [1:0]           lh_to_reg;
  } exmem_t;

  state_t               r_state, w_next;
  exmem_t               r_cap, w_in, w_src;
  logic                 w_misalign, w_start_mem, w_fire, w_bad;
  logic [3:0]           w_wstrb;
  logic [31:0]          w_wdata, w_load;
  logic [DATA_BITS-1:0] w_wb_data;

  always_comb begin
    w_in.pc          = pc_in;
    w_in.ir          = ir_in;
    w_in.r1          = result_1;
    w_in.r2          = result_2;
    w_in.sd          = store_data;
    w_in.lo          = lo;
    w_in.hi          = hi;
    w_in.write       = write;
    w_in.mem_to_reg  = MemToReg;
    w_in.mem_write   = MemWrite;
    w_in.reg_write   = RegWrite;
    w_in.jal         = Jal;
    w_in.to_lh       = ToLH;
    w_in.sh          = Sh;
    w_in.sb          = Sb;
    w_in.extr_signed = ExtrSigned;
    w_in.syscall     = Syscall;
    w_in.extr_word   = ExtrWord;
    w_in.lh_to_reg   = LHToReg;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(result_1[1:0], MemWrite, Sb, Sh, ExtrWord);
`else
  assign w_misalign = 1'b0;
`endif

  // A misaligned memory op never reaches ACCESS; it retires like an ALU op.
  assign w_start_mem = valid_in & (MemToReg | MemWrite) & ~w_misalign;
  assign w_bad       = (r_state == IDLE) & valid_in & w_misalign;
  assign w_fire      = (r_state == IDLE)   ? (valid_in & ~w_start_mem)
                                           : dmem.dmem_ack;
  assign w_src       = (r_state == ACCESS) ? r_cap : w_in;

  mem_lane_align u_lane (
    .i_addr_lo     (r_cap.r1[1:0]),
    .i_sb          (r_cap.sb),
    .i_sh          (r_cap.sh),
    .i_store_data  (r_cap.sd[31:0]),
    .i_rdata       (dmem.dmem_rdata[31:0]),
    .i_extr_word   (r_cap.extr_word),
    .i_extr_signed (r_cap.extr_signed),
    .o_wstrb       (w_wstrb),
    .o_wdata       (w_wdata),
    .o_load_data   (w_load)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_mem)   w_next = ACCESS;
      ACCESS:  if (dmem.dmem_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_busy        = (r_state == IDLE) ? w_start_mem : ~dmem.dmem_ack;
    dmem.dmem_req   = (r_state == ACCESS);
    dmem.dmem_we    = (r_state == ACCESS) & r_cap.mem_write;
    dmem.dmem_addr  = {r_cap.r1[DATA_BITS-1:2], 2'b00};
    dmem.dmem_wstrb = (r_state == ACCESS) ? w_wstrb : 4'b0000;
    dmem.dmem_wdata = w_wdata;
    o_dbg_state     = r_state;
  end

  always_comb begin
    case (lh_sel_t'(w_src.lh_to_reg))
      LH_LO:   w_wb_data = w_src.lo;
      LH_HI:   w_wb_data = w_src.hi;
      default: begin
        if (w_src.jal)             w_wb_data = DATA_BITS'(w_src.pc + PC_BITS'(4));
        else if (w_src.mem_to_reg) w_wb_data = w_load;
        else                       w_wb_data = w_src.r1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                     r_cap <= '0;
    else if ((r_state == IDLE) && w_start_mem)   r_cap <= w_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_ToLH     <= 1'b0;
      wb_Syscall  <= 1'b0;
      wb_write    <= '0;
      wb_data     <= '0;
      wb_result_1 <= '0;
      wb_result_2 <= '0;
      wb_pc       <= '0;
      wb_ir       <= '0;
    end else if (w_fire) begin
      wb_valid    <= 1'b1;
      wb_RegWrite <= w_src.reg_write & ~w_src.mem_write & ~w_bad;
      wb_ToLH     <= w_src.to_lh;
      wb_Syscall  <= w_src.syscall;
      wb_write    <= w_src.write;
      wb_data     <= w_wb_data;
      wb_result_1 <= w_src.r1;
      wb_result_2 <= w_src.r2;
      wb_pc       <= w_src.pc;
      wb_ir       <= w_src.ir;
    end else begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_ToLH     <= 1'b0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) wb_addr_err <= 1'b0;
    else     wb_addr_err <= w_fire & w_bad;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; the bench itself plays the data memory.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] pc_in, ir_in, result_1, result_2, store_data, lo, hi;
  logic [5:0]  write;
  logic        MemToReg, MemWrite, RegWrite, Jal, ToLH, Sh, Sb, ExtrSigned, Syscall;
  logic [1:0]  ExtrWord, LHToReg;
  logic        mem_busy;
  logic        wb_valid, wb_RegWrite, wb_ToLH, wb_Syscall;
  logic [5:0]  wb_write;
  logic [31:0] wb_data, wb_result_1, wb_result_2, wb_pc, wb_ir;
`ifdef MEM_ALIGN_CHECK_EN
  logic        wb_addr_err;
`endif
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if dmem_if ();

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .ir_in(ir_in),
    .result_1(result_1), .result_2(result_2), .store_data(store_data), .write(write),
    .MemToReg(MemToReg), .MemWrite(MemWrite), .RegWrite(RegWrite), .Jal(Jal),
    .ToLH(ToLH), .Sh(Sh), .Sb(Sb), .ExtrSigned(ExtrSigned), .Syscall(Syscall),
    .ExtrWord(ExtrWord), .LHToReg(LHToReg), .lo(lo), .hi(hi),
    .mem_busy(mem_busy), .dmem(dmem_if),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_ToLH(wb_ToLH),
    .wb_Syscall(wb_Syscall), .wb_write(wb_write), .wb_data(wb_data),
    .wb_result_1(wb_result_1), .wb_result_2(wb_result_2), .wb_pc(wb_pc), .wb_ir(wb_ir),
`ifdef MEM_ALIGN_CHECK_EN
    .wb_addr_err(wb_addr_err),
`endif
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; pc_in = 0; ir_in = 0; result_1 = 0; result_2 = 0; store_data = 0;
    lo = 0; hi = 0; write = 0; MemToReg = 0; MemWrite = 0; RegWrite = 0; Jal = 0;
    ToLH = 0; Sh = 0; Sb = 0; ExtrSigned = 0; Syscall = 0; ExtrWord = 0; LHToReg = 0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    clear_inputs();
    valid_in = 1; MemToReg = 1; RegWrite = 1; write = 6'd7;
    result_1 = addr; ExtrWord = size; ExtrSigned = sgn; pc_in = 32'h100; ir_in = 32'h8c00_0000;
  endtask

  // Accept edge, one ACCESS cycle with ack, then the WB edge.
  task automatic ack_next(input logic [31:0] rdata);
    tick();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = rdata;
    tick();
    dmem_if.dmem_ack = 0;
    clear_inputs();
  endtask

  int req_cnt, busy_cnt, wbv_cnt;

  initial begin
    clear_inputs();
    dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = 0;
    rst = 1;
    repeat (3) tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst_req", dmem_if.dmem_req, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_state", dbg_state, IDLE);
    rst = 0;
    tick();

    // Signed lb at 0x1003
    drive_load(32'h1003, EXTR_BYTE, 1);
    #1 chk("lb_busy_accept", mem_busy, 1);
    chk("lb_req_idle", dmem_if.dmem_req, 0);
    tick();
    chk("lb_req", dmem_if.dmem_req, 1);
    chk("lb_addr", dmem_if.dmem_addr, 32'h1000);
    chk("lb_wstrb_load", dmem_if.dmem_wstrb, 4'b1111);
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h80AA_BBCC;
    #1 chk("lb_busy_ack", mem_busy, 0);
    tick();
    dmem_if.dmem_ack = 0; clear_inputs();
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_regwrite", wb_RegWrite, 1);
    chk("lb_wb_write", wb_write, 6'd7);
    tick();
    chk("lb_wb_valid_once", wb_valid, 0);
    chk("lb_req_after", dmem_if.dmem_req, 0);

    // sh at 0x2002
    clear_inputs();
    valid_in = 1; MemWrite = 1; Sh = 1; RegWrite = 1; result_1 = 32'h2002; store_data = 32'h0000_1234;
    tick();
    chk("sh_we", dmem_if.dmem_we, 1);
    chk("sh_wstrb", dmem_if.dmem_wstrb, 4'b1100);
    chk("sh_wdata", dmem_if.dmem_wdata, 32'h1234_1234);
    chk("sh_addr", dmem_if.dmem_addr, 32'h2000);
    dmem_if.dmem_ack = 1;
    tick();
    dmem_if.dmem_ack = 0; clear_inputs();
    chk("sh_wb_valid", wb_valid, 1);
    chk("sh_wb_regwrite", wb_RegWrite, 0);
    tick();

    // sb at 0x7001
    clear_inputs();
    valid_in = 1; MemWrite = 1; Sb = 1; result_1 = 32'h7001; store_data = 32'h5566_77AB;
    tick();
    chk("sb_wstrb", dmem_if.dmem_wstrb, 4'b0010);
    chk("sb_wdata", dmem_if.dmem_wdata, 32'hABAB_ABAB);
    dmem_if.dmem_ack = 1;
    tick();
    dmem_if.dmem_ack = 0; clear_inputs();
    tick();
    chk("sb_wstrb_idle", dmem_if.dmem_wstrb, 4'b0000);

    // lw with ack delayed by 3 cycles
    req_cnt = 0; busy_cnt = 0; wbv_cnt = 0;
    drive_load(32'h3000, EXTR_WORD, 0);
    #1;
    if (dmem_if.dmem_req) req_cnt++;
    if (mem_busy) busy_cnt++;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'hDEAD_BEEF; end
      #1;
      if (dmem_if.dmem_req) req_cnt++;
      if (mem_busy) busy_cnt++;
      if (wb_valid) wbv_cnt++;
      chk($sformatf("lw_addr_c%0d", i), dmem_if.dmem_addr, 32'h3000);
      tick();
    end
    dmem_if.dmem_ack = 0; clear_inputs();
    chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      if (wb_valid) wbv_cnt++;
      tick();
    end
    chk("lw_req_cycles", req_cnt, 4);
    chk("lw_busy_cycles", busy_cnt, 4);
    chk("lw_wb_valid_count", wbv_cnt, 1);

    // Halfword loads
    drive_load(32'h6002, EXTR_HALF, 0);
    ack_next(32'h8001_1234);
    chk("lhu_data", wb_data, 32'h0000_8001);
    drive_load(32'h6000, EXTR_HALF, 1);
    ack_next(32'h8001_F234);
    chk("lh_data", wb_data, 32'hFFFF_F234);
    tick();

    // Three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      valid_in = 1; RegWrite = 1; result_1 = 32'h11 * (i + 1); write = 6'(i + 1);
      #1 chk($sformatf("add%0d_busy", i), mem_busy, 0);
      tick();
      chk($sformatf("add%0d_wb_valid", i), wb_valid, 1);
      chk($sformatf("add%0d_wb_data", i), wb_data, 32'h11 * (i + 1));
    end
    clear_inputs();
    tick();
    chk("add_idle_wb_valid", wb_valid, 0);
    chk("add_idle_regwrite", wb_RegWrite, 0);

    // wb_data priority: HI/LO over Jal over result_1
    clear_inputs();
    valid_in = 1; RegWrite = 1; Jal = 1; pc_in = 32'h400; result_1 = 32'h99;
    tick();
    chk("jal_data", wb_data, 32'h404);
    clear_inputs();
    valid_in = 1; RegWrite = 1; Jal = 1; LHToReg = LH_HI; hi = 32'hCAFE_0000; lo = 32'h1;
    tick();
    chk("mfhi_data", wb_data, 32'hCAFE_0000);
    clear_inputs();
    valid_in = 1; RegWrite = 1; ToLH = 1; LHToReg = LH_LO; hi = 32'h2; lo = 32'h0BAD_F00D;
    tick();
    chk("mflo_data", wb_data, 32'h0BAD_F00D);
    chk("tolh_flag", wb_ToLH, 1);
    clear_inputs();
    tick();
    chk("tolh_cleared", wb_ToLH, 0);

    // Reset during ACCESS, then a stray ack
    drive_load(32'h5000, EXTR_WORD, 0);
    tick();
    chk("rsta_req", dmem_if.dmem_req, 1);
    rst = 1;
    tick();
    rst = 0; clear_inputs();
    chk("rsta_req_after", dmem_if.dmem_req, 0);
    chk("rsta_state", dbg_state, IDLE);
    chk("rsta_wb_valid", wb_valid, 0);
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h1234_5678;
    tick();
    dmem_if.dmem_ack = 0;
    chk("stray_ack_wb_valid", wb_valid, 0);
    chk("stray_ack_state", dbg_state, IDLE);
    chk("stray_ack_req", dmem_if.dmem_req, 0);

`ifdef MEM_ALIGN_CHECK_EN
    drive_load(32'h1002, EXTR_WORD, 0);
    #1 chk("mis_busy", mem_busy, 0);
    tick();
    clear_inputs();
    chk("mis_req", dmem_if.dmem_req, 0);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_addr_err", wb_addr_err, 1);
    chk("mis_regwrite", wb_RegWrite, 0);
    tick();
    chk("mis_addr_err_clr", wb_addr_err, 0);
    chk("mis_req_after", dmem_if.dmem_req, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs and drives a handshaked data-memory port that may take several cycles per access.
- Builds byte/halfword store strobes and extracts load data.
- Produces a registered MEM/WB bundle and stalls upstream while an access is outstanding.

Parameters:
- PC_BITS, 32, PC width
- IR_BITS, 32, instruction width
- DATA_BITS, 32, datapath width; only 32 is supported

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  EX/MEM slot holds a live instruction
- pc_in  in  PC_BITS  instruction PC
- ir_in  in  IR_BITS  instruction word
- result_1  in  DATA_BITS  ALU result / memory address
- result_2  in  DATA_BITS  second ALU result (HI part)
- store_data  in  DATA_BITS  rt value to store
- write  in  6  destination register index
- MemToReg, MemWrite, RegWrite, Jal, ToLH, Sh, Sb, ExtrSigned, Syscall  in  1 each  control bits from EX/MEM
- ExtrWord  in  2  load size: 00 word, 01 byte, 10 halfword, 11 word
- LHToReg  in  2  01 select lo, 10 select hi
- lo, hi  in  DATA_BITS  HI/LO values
- mem_busy  out  1  upstream hold; EX/MEM advances only when 0
- dmem_req  out  1  access request
- dmem_we  out  1  write request
- dmem_addr  out  DATA_BITS  word-aligned address (result_1 with bits [1:0] = 0)
- dmem_wstrb  out  4  byte-lane write enables
- dmem_wdata  out  DATA_BITS  lane-replicated store data
- dmem_rdata  in  DATA_BITS  read data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- wb_valid, wb_RegWrite, wb_ToLH, wb_Syscall  out  1 each  MEM/WB bundle
- wb_write  out  6  destination register index
- wb_data  out  DATA_BITS  final register-file write value
- wb_result_1, wb_result_2  out  DATA_BITS  HI/LO write values
- wb_pc  out  PC_BITS  PC
- wb_ir  out  IR_BITS  instruction word

Behaviour:
- Reset: every output register is 0; FSM goes to IDLE. A reset asserted in ACCESS abandons the access: dmem_req is 0 on the next cycle, no wb_valid pulse, and a later ack is ignored.
- FSM states:
  - IDLE: a non-memory op (valid_in & ~MemToReg & ~MemWrite) registers its WB bundle at the clock edge. wb_valid = 1 for one cycle, mem_busy = 0.
  - IDLE: a memory op (valid_in & (MemToReg | MemWrite)) drives mem_busy = 1 combinationally, captures all inputs, and goes to ACCESS.
  - ACCESS: dmem_req = 1 and address/strobe/data are held stable from the captured copy. mem_busy = 1. On dmem_ack, register the WB bundle (loads use dmem_rdata), set wb_valid = 1, go to IDLE, and drop mem_busy the same cycle so the next instruction is accepted on that edge.
- Memory-op latency: at least 2 cycles, namely accept, then ack cycle, then wb_valid.
- Outside ACCESS: dmem_req = 0, dmem_wstrb = 0.
- A cycle with no valid instruction sets wb_valid = 0 and clears wb_RegWrite and wb_ToLH.
- Store lanes (little-endian, a = result_1[1:0]):
  - Sb: wstrb = 1 << a, wdata = byte repeated ×4.
  - Sh: wstrb = a[1] ? 1100 : 0011, wdata = halfword repeated ×2.
  - otherwise: wstrb = 1111.
  - dmem_we = MemWrite.
- Load extraction:
  - byte = rdata[8a+7:8a].
  - half = rdata[16·a[1]+15:16·a[1]].
  - ExtrSigned = 1 sign-extends, 0 zero-extends.
- wb_data priority:
  1. LHToReg = 01 → lo; LHToReg = 10 → hi
  2. Jal → pc_in + 4
  3. MemToReg → extracted load data
  4. otherwise result_1
- Stores set wb_RegWrite = 0 regardless of RegWrite.
- dmem_ack seen in IDLE is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - An access is misaligned if a[0] ≠ 0 for halfword, or a ≠ 0 for word.
  - A misaligned access skips ACCESS and issues no dmem_req.
  - Result is one wb_valid with wb_RegWrite = 0, plus extra output wb_addr_err = 1.
- When undefined: no check, no wb_addr_err port, and address low bits only select lanes.

Decomposition:
- Shared package holds the ExtrWord encodings, the LHToReg encodings, and the FSM state enum (IDLE, ACCESS).
- One natural sub-module, mem_lane_align: purely combinational strobe, replication and load-extraction logic. The FSM and WB registers stay in mem_stage.

Test Plan:
- Signed lb, result_1 = 0x1003, rdata = 0x80AABBCC, ack after 1 cycle → dmem_addr = 0x1000, wb_data = 0xFFFFFF80, wb_valid pulses once.
- sh, result_1 = 0x2002, store_data = 0x00001234 → wstrb = 1100, wdata = 0x12341234, wb_RegWrite = 0.
- lw with ack delayed 3 cycles → dmem_req and mem_busy high 4 cycles, address stable throughout, exactly one wb_valid.
- Three back-to-back add ops → mem_busy stays 0, wb_valid high 3 consecutive cycles, wb_data = result_1 each cycle.
- rst asserted during ACCESS, then stray ack → dmem_req = 0 next cycle, no wb_valid, FSM in IDLE.
- With MEM_ALIGN_CHECK_EN, lw at 0x1002 → no dmem_req, wb_addr_err = 1, wb_RegWrite = 0.
